vga_glyph_sequencer: RTL and testbench
======================================

VGA_GLYPH_SEQUENCER -- requirements
Module: vga_glyph_sequencer

Interface
REQ-001 Parameters: none; timing fixed at 640x480, 800x525 total, one pixel per clk.
REQ-002 clk  input  1  pixel clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 mem_addr  output  12  shared character-RAM address, row*80+col.
REQ-005 mem_rd / mem_wr  output  1 each  character-RAM read / write strobes, never both high.
REQ-006 mem_wdata  output  8  write data, equals host_data while mem_wr=1.
REQ-007 mem_rdata  input  8  character code, valid the cycle after mem_rd.
REQ-008 rom_addr  output  12  glyph-ROM address {char[7:0], glyph_row[3:0]}.
REQ-009 rom_data  input  8  glyph row bitmap, bit 7 leftmost, valid the cycle after rom_addr changes.
REQ-010 host_req  input  1  host write request, held until host_ack.
REQ-011 host_addr / host_data  input  12 / 8  write target and data, stable while host_req=1.
REQ-012 host_ack  output  1  one-cycle pulse, write performed that cycle.
REQ-013 hsync / vsync  output  1 each  active-low sync.
REQ-014 de / pixel / frame_start  output  1 each  display enable, glyph pixel, one-cycle pulse at (h,v)=(0,0).

Function
REQ-015 hcnt 0..799 increments every cycle and wraps to 0; vcnt 0..524 increments on hcnt wrap and wraps to 0.
REQ-016 Active region h<640 and v<480; hsync low for h 656..751; vsync low for v 490..491.
REQ-017 hsync, vsync, de, pixel and frame_start are registered: values for counter (h,v) appear the cycle after the counters hold (h,v).
REQ-018 Cell geometry 8x16: col=h[9:3] (0..79), glyph_row=v[3:0], text row=v[8:4] (0..29).
REQ-019 Fetch slot per cell, phase p=h[2:0], targeting the next cell (col+1, or col 0 when h in 792..799):
  p=0: mem_rd=1, mem_addr=target address;
  p=1: latch mem_rdata, drive rom_addr;
  p=2: latch rom_data into next_bits;
  p=7: load shift register from next_bits.
REQ-020 Fetches run only for lines v<480, at h in 0..631 and 792..799; no display reads elsewhere.
REQ-021 Shift register shifts left one bit per cycle outside p=7; pixel = shift[7] when de, else 0.
REQ-022 Arbitration: display read owns the port on fetch-slot p=0 cycles; host write is granted on any other cycle.
REQ-023 On grant: mem_wr=1, mem_addr=host_addr, mem_wdata=host_data, host_ack=1 in the same cycle; at most one grant per request.
REQ-024 host_req arriving on a reserved p=0 cycle is acknowledged on the following cycle (worst-case latency 2 cycles from req).
REQ-025 host_ack requires host_req low for at least one cycle before a new request is accepted; back-to-back held req is not re-acked.
REQ-026 host_addr >= 2400 is acknowledged and written unchanged; no range check.
REQ-027 mem_addr when neither strobe is high: 0.

Reset
REQ-028 While rst=1: hcnt=vcnt=0, shift=next_bits=0, hsync=vsync=1, de=pixel=frame_start=0, mem_rd=mem_wr=host_ack=0, mem_addr=rom_addr=0.
REQ-029 A host request in progress at reset is dropped; no ack until after rst falls.
REQ-030 First cycle after rst falls: counters at (0,0); frame_start asserts on the next cycle; the first line's col-0 cell displays 0 (no prefetch occurred).

Verification
REQ-031 Free run 2 frames: hsync low 96 cycles per 800, vsync low 1600 cycles per 420000, de high 307200 cycles per frame, frame_start exactly once per frame.
REQ-032 RAM all 0x41, ROM returns 0xF0 for every address: active-region pixel pattern 11110000 repeating from line 1 col 0, pixel=0 in blanking.
REQ-033 host_req with addr=0x005, data=0x7E raised at h=8 (p=0): host_ack at h=9, mem_wr=1 with mem_addr=0x005, mem_wdata=0x7E; no collision with mem_rd.
REQ-034 host_req held high 10 cycles at h=100: exactly one host_ack, at h=100; req low then high again at h=200 gives a second ack.
REQ-035 rst pulsed mid-line at h=300, v=50 with host_req high: all outputs take reset values asynchronously, no host_ack during reset, counters restart at (0,0).
REQ-036 Check rom_addr at p=1 for cell (col=3, v=37): {mem_rdata of address 2*80+4, 4'd5}.

Source files
------------

// File: rtl/vga_glyph_sequencer.sv
// 640x480 text-mode VGA sequencer: 80x30 cells of 8x16 glyphs fetched through a shared
// character RAM and a glyph ROM, with host writes slotted around the display reads.
module vga_glyph_sequencer (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        host_req,
    input  logic [11:0] host_addr,
    input  logic [7:0]  host_data,
    output logic        host_ack,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pixel,
    output logic        frame_start
);
    localparam int unsigned HW          = 10;
    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned H_SYNC_BEG  = 656;
    localparam int unsigned H_SYNC_END  = 751;
    localparam int unsigned H_FETCH_END = 631;
    localparam int unsigned H_PRE_BEG   = 792;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned V_SYNC_BEG  = 490;
    localparam int unsigned V_SYNC_END  = 491;
    localparam int unsigned COLS        = 80;

    typedef enum logic {HOST_IDLE, HOST_WAIT_LOW} host_state_t;

    logic [HW-1:0] hcnt;
    logic [HW-1:0] vcnt;
    logic [7:0]    shift_q;
    logic [7:0]    next_bits_q;
    logic [11:0]   rom_addr_q;
    host_state_t   host_state;
    host_state_t   host_state_nxt;

    logic [2:0]    phase;
    logic          pre_zone;
    logic          fetch_win;
    logic          display_slot;
    logic          active;
    logic          grant;
    logic [6:0]    tgt_col;
    logic [8:0]    tgt_line;
    logic [11:0]   tgt_addr;

    // Fetch targets the next cell; the pre-line slot at h 792..799 targets col 0 of the next line.
    always_comb begin : fetch_decode
        phase        = hcnt[2:0];
        pre_zone     = (hcnt >= HW'(H_PRE_BEG));
        fetch_win    = (vcnt < HW'(V_ACTIVE)) && ((hcnt <= HW'(H_FETCH_END)) || pre_zone);
        tgt_col      = pre_zone ? 7'd0 : 7'(hcnt[9:3] + 7'd1);
        tgt_line     = pre_zone ? 9'(vcnt + HW'(1)) : vcnt[8:0];
        tgt_addr     = 12'(tgt_line[8:4]) * 12'(COLS) + 12'(tgt_col);
        display_slot = !rst && fetch_win && (phase == 3'd0);
        active       = (hcnt < HW'(H_ACTIVE)) && (vcnt < HW'(V_ACTIVE));
    end

    always_ff @(posedge clk or posedge rst) begin : host_state_reg
        if (rst) begin
            host_state <= HOST_IDLE;
        end else begin
            host_state <= host_state_nxt;
        end
    end

    // One grant per request; the request must drop before the next one is accepted.
    always_comb begin : host_fsm
        host_state_nxt = host_state;
        grant          = 1'b0;
        case (host_state)
            HOST_IDLE: begin
                if (host_req && !display_slot && !rst) begin
                    grant          = 1'b1;
                    host_state_nxt = HOST_WAIT_LOW;
                end
            end
            HOST_WAIT_LOW: begin
                if (!host_req) begin
                    host_state_nxt = HOST_IDLE;
                end
            end
            default: host_state_nxt = HOST_IDLE;
        endcase
    end

    always_comb begin : port_mux
        mem_rd    = display_slot;
        mem_wr    = grant;
        host_ack  = grant;
        mem_wdata = grant ? host_data : 8'd0;
        mem_addr  = 12'd0;
        if (display_slot) begin
            mem_addr = tgt_addr;
        end else if (grant) begin
            mem_addr = host_addr;
        end
        rom_addr = rom_addr_q;
        if (!rst && fetch_win && (phase == 3'd1)) begin
            rom_addr = {mem_rdata, tgt_line[3:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin : counters
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == HW'(H_TOTAL - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == HW'(V_TOTAL - 1)) ? '0 : HW'(vcnt + HW'(1));
        end else begin
            hcnt <= HW'(hcnt + HW'(1));
        end
    end

    // Glyph pipeline; outside fetch windows the shifter drains to zero instead of reloading.
    always_ff @(posedge clk or posedge rst) begin : glyph_pipe
        if (rst) begin
            rom_addr_q  <= '0;
            next_bits_q <= '0;
            shift_q     <= '0;
        end else begin
            if (fetch_win && (phase == 3'd1)) begin
                rom_addr_q <= {mem_rdata, tgt_line[3:0]};
            end
            if (fetch_win && (phase == 3'd2)) begin
                next_bits_q <= rom_data;
            end
            if (fetch_win && (phase == 3'd7)) begin
                shift_q <= next_bits_q;
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : video_out
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pixel       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !((hcnt >= HW'(H_SYNC_BEG)) && (hcnt <= HW'(H_SYNC_END)));
            vsync       <= !((vcnt >= HW'(V_SYNC_BEG)) && (vcnt <= HW'(V_SYNC_END)));
            de          <= active;
            pixel       <= active && shift_q[7];
            frame_start <= (hcnt == '0) && (vcnt == '0);
        end
    end
endmodule

// File: tb/tb_vga_glyph_sequencer.sv
// Bench for vga_glyph_sequencer: host-write scoreboard, per-line video model and
// directed fetch/reset probes against a character RAM and constant 0xF0 glyph ROM.
module tb_vga_glyph_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        host_req = 1'b0;
    logic [11:0] host_addr = 12'h000;
    logic [7:0]  host_data = 8'h00;
    logic        host_ack;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        pixel;
    logic        frame_start;

    vga_glyph_sequencer dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack),
        .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          line;
        int          hpos;
        logic [11:0] addr;
        logic [7:0]  data;
    } ack_t;

    ack_t       exp_q[$];
    ack_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    int         collisions = 0;
    int         idle_addr_errs = 0;
    logic [7:0] ram [0:4095];

    // Reference timeline: counter value of the current cycle and of the previous one.
    int tb_h = 0, tb_v = 0, ph = 0, pv = 0;
    bit pvalid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_h <= 0; tb_v <= 0; pvalid <= 1'b0;
        end else begin
            ph <= tb_h; pv <= tb_v; pvalid <= 1'b1;
            tb_h <= (tb_h == 799) ? 0 : tb_h + 1;
            if (tb_h == 799) tb_v <= (tb_v == 524) ? 0 : tb_v + 1;
        end
    end

    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
        rom_data <= 8'hF0;
    end

    function automatic logic [4:0] disp_model(input int h, input int v);
        logic act_px, px;
        act_px = (h < 640) && (v < 480);
        px     = act_px && ((h % 8) < 4) && !((v == 0) && (h < 8));
        return {!((h >= 656) && (h <= 751)), !((v >= 490) && (v <= 491)), act_px, px, (h == 0) && (v == 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (v=%0d h=%0d)", name, act, exp, tb_v, tb_h);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Scoreboard monitor: every host_ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (host_ack) begin
            tests++;
            if (rst || exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: v=%0d h=%0d addr=%h rst=%b, expected no ack", tb_v, tb_h, mem_addr, rst);
            end else begin
                mon_e = exp_q.pop_front();
                if (tb_v != mon_e.line || tb_h != mon_e.hpos || mem_wr !== 1'b1 || mem_rd !== 1'b0 ||
                    mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    fails++;
                    $display("FAIL host_ack: got v=%0d h=%0d wr=%b rd=%b addr=%h data=%h, expected v=%0d h=%0d wr=1 rd=0 addr=%h data=%h",
                             tb_v, tb_h, mem_wr, mem_rd, mem_addr, mem_wdata, mon_e.line, mon_e.hpos, mon_e.addr, mon_e.data);
                end
            end
        end
        if (mem_rd && mem_wr) collisions++;
        if (!mem_rd && !mem_wr && mem_addr != 12'd0) idle_addr_errs++;
    end

    int         line_err = 0, first_h = 0, first_v = 0;
    logic [4:0] exp_disp, act_disp, first_act, first_exp;

    // Video monitor: one comparison per line over {hsync,vsync,de,pixel,frame_start}.
    always @(negedge clk) begin
        if (!rst) begin
            exp_disp = pvalid ? disp_model(ph, pv) : 5'b11000;
            act_disp = {hsync, vsync, de, pixel, frame_start};
            if (act_disp !== exp_disp) begin
                if (line_err == 0) begin
                    first_h = tb_h; first_v = tb_v; first_act = act_disp; first_exp = exp_disp;
                end
                line_err++;
            end
            if (tb_h == 799) begin
                tests++;
                if (line_err != 0) begin
                    fails++;
                    $display("FAIL line_video v=%0d: %0d bad cycles, first at v=%0d h=%0d got %b expected %b",
                             tb_v, line_err, first_v, first_h, first_act, first_exp);
                end
                line_err = 0;
            end
        end
    end

    task automatic wait_at(input int v, input int h);
        int n;
        n = 0;
        while (!(tb_v == v && tb_h == h)) begin
            @(posedge clk); #1;
            n++;
            if (n > 60000) begin
                tests++; fails++;
                $display("FAIL wait_at: timeout reaching v=%0d h=%0d", v, h);
                finish_run();
            end
        end
    endtask

    task automatic host_write(input int v, input int h, input int ack_h,
                              input logic [11:0] a, input logic [7:0] d, input int hold);
        ack_t e;
        wait_at(v, h);
        e.line = v; e.hpos = ack_h; e.addr = a; e.data = d;
        exp_q.push_back(e);
        host_addr = a; host_data = d; host_req = 1'b1;
        repeat (hold) @(posedge clk);
        #1 host_req = 1'b0;
    endtask

    task automatic release_and_check_fs();
        @(negedge clk);
        #1 rst = 1'b0;
        #2 check("fs_low_at_00", {31'd0, frame_start}, 32'd0);
        @(negedge clk) check("fs_pulse", {31'd0, frame_start}, 32'd1);
        @(negedge clk) check("fs_single", {31'd0, frame_start}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h41;
        ram[164] = 8'h5A;
        repeat (3) @(negedge clk);
        check("reset_outputs", {hsync, vsync, de, pixel, frame_start, mem_rd, mem_wr, host_ack, mem_addr, rom_addr},
              {8'hC0, 12'h000, 12'h000});
        release_and_check_fs();

        host_write(1,   8,   9, 12'h005, 8'h7E,  2);
        host_write(1, 100, 100, 12'h010, 8'h11, 10);
        host_write(1, 200, 201, 12'h011, 8'h22,  3);
        host_write(1, 300, 300, 12'hFFF, 8'h33,  2);
        host_write(1, 400, 401, 12'h960, 8'h44,  3);
        host_write(2, 640, 640, 12'h020, 8'h55,  2);
        host_write(2, 792, 793, 12'h021, 8'h66,  3);
        host_write(3,   0,   1, 12'h030, 8'h77,  3);

        wait_at(37, 24);  check("fetch_rd_addr", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 12'd164});
        wait_at(37, 25);  check("rom_addr_p1", {mem_rd, rom_addr}, {1'b0, 12'h5A5});
        wait_at(37, 26);  check("rom_addr_p2", {20'd0, rom_addr}, {20'd0, 12'h5A5});
        wait_at(37, 640); check("no_fetch_blank", {mem_rd, mem_addr}, 32'd0);
        wait_at(37, 792); check("prefetch_addr", {mem_rd, mem_addr}, {1'b1, 12'd160});
        wait_at(37, 793); check("prefetch_rom", {20'd0, rom_addr}, {20'd0, 12'h416});

        wait_at(50, 300);
        rst = 1'b1; host_req = 1'b1; host_addr = 12'h123; host_data = 8'h99;
        #1 check("async_reset", {hsync, vsync, de, pixel, frame_start, mem_rd, mem_wr, host_ack, mem_addr, rom_addr},
                 {8'hC0, 12'h000, 12'h000});
        repeat (3) @(negedge clk);
        check("no_ack_in_reset", {31'd0, host_ack}, 32'd0);
        host_req = 1'b0;
        release_and_check_fs();

        wait_at(3, 10);
        check("pending_acks", exp_q.size(), 32'd0);
        check("rd_wr_collision", collisions, 32'd0);
        check("idle_addr_zero", idle_addr_errs, 32'd0);
        finish_run();
    end
endmodule
